mux_rr_sched: RTL and testbench

Round-robin scheduler that shares one `mux_8to1` datapath among eight requesters. It accepts per-requester request lines, grants one requester at a time, and drives the 3-bit `ctrl` select of the mux. Grants rotate fairly, and a hold limit stops any requester from monopolising the mux. The scheduler sits directly in front of `mux_8to1`: `sel` connects to the mux `ctrl` input.

---
 rtl/mux_sched_defs.sv | 18 +
 rtl/rr_pick8.sv | 31 +++
 rtl/mux_rr_sched.sv | 111 +++++++++++
 tb/tb_mux_rr_sched.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/mux_sched_defs.sv
// Shared definitions for the eight-way round-robin mux scheduler.
package mux_sched_defs;
  localparam int N     = 8;
  localparam int SEL_W = 3;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  // Reset pointer sits on the last requester so the first scan starts at 0.
  localparam logic [SEL_W-1:0] LAST_RST = 3'd7;
  localparam logic [3:0]       HCNT_SAT = 4'd15;

  function automatic logic [N-1:0] idx2onehot(input logic [SEL_W-1:0] i);
    idx2onehot = 8'b0000_0001 << i;
  endfunction
endpackage

// File: rtl/rr_pick8.sv
// Wrap-around priority scan: first set request after start, start itself last,
// optionally skipping one excluded index.
module rr_pick8
  import mux_sched_defs::*;
(
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] start,
  input  logic             excl_en,
  input  logic [SEL_W-1:0] excl_idx,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] cand_s;
  logic             hit_s;

  // Scan farthest-first so the nearest eligible candidate overwrites the result.
  always_comb begin
    found  = 1'b0;
    idx    = start;
    cand_s = start;
    hit_s  = 1'b0;
    for (int k = N; k >= 1; k--) begin
      cand_s = start + SEL_W'(k);
      hit_s  = req[cand_s] & ~(excl_en & (cand_s == excl_idx));
      found  = found | hit_s;
      idx    = hit_s ? cand_s : idx;
    end
  end

endmodule

// File: rtl/mux_rr_sched.sv
// Round-robin scheduler driving the select of a shared 8:1 mux, with a hold
// limit that forces rotation when another requester is waiting.
module mux_rr_sched
  import mux_sched_defs::*;
#(
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     gnt,
  output logic [SEL_W-1:0] sel,
  output logic             busy
);

  localparam logic [3:0] MAX_HOLD_C = 4'(MAX_HOLD);

  state_e           state_r, state_s;
  logic [N-1:0]     gnt_r, gnt_s;
  logic [SEL_W-1:0] sel_r, sel_s;
  logic [SEL_W-1:0] last_r, last_s;
  logic [3:0]       hcnt_r, hcnt_s;
  logic             busy_r;

  logic             owner_req_s;
  logic             others_s;
  logic             excl_en_s;
  logic             found_s;
  logic [SEL_W-1:0] pick_s;
  logic [3:0]       hcnt_inc_s;

  assign owner_req_s = |(req & gnt_r);
  assign others_s    = |(req & ~gnt_r);
  // Exclusion only matters on a forced rotation; a releasing owner is already absent from req.
  assign excl_en_s   = (state_r == ST_GRANT) & owner_req_s;
  assign hcnt_inc_s  = (hcnt_r == HCNT_SAT) ? HCNT_SAT : (hcnt_r + 4'd1);

  rr_pick8 u_pick (
    .req      (req),
    .start    (last_r),
    .excl_en  (excl_en_s),
    .excl_idx (last_r),
    .found    (found_s),
    .idx      (pick_s)
  );

  // Next-state and next-output decision.
  always_comb begin
    state_s = state_r;
    gnt_s   = gnt_r;
    sel_s   = sel_r;
    last_s  = last_r;
    hcnt_s  = hcnt_r;
    case (state_r)
      ST_IDLE: begin
        if (found_s) begin
          state_s = ST_GRANT;
          gnt_s   = idx2onehot(pick_s);
          sel_s   = pick_s;
          last_s  = pick_s;
          hcnt_s  = 4'd1;
        end else begin
          gnt_s   = {N{1'b0}};
        end
      end
      ST_GRANT: begin
        if (!owner_req_s || ((hcnt_r >= MAX_HOLD_C) && others_s)) begin
          if (found_s) begin
            gnt_s   = idx2onehot(pick_s);
            sel_s   = pick_s;
            last_s  = pick_s;
            hcnt_s  = 4'd1;
          end else begin
            state_s = ST_IDLE;
            gnt_s   = {N{1'b0}};
          end
        end else begin
          hcnt_s = hcnt_inc_s;
        end
      end
      default: begin
        state_s = ST_IDLE;
        gnt_s   = {N{1'b0}};
      end
    endcase
  end

  // State, pointer, counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      gnt_r   <= {N{1'b0}};
      sel_r   <= {SEL_W{1'b0}};
      last_r  <= LAST_RST;
      hcnt_r  <= 4'd0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      gnt_r   <= gnt_s;
      sel_r   <= sel_s;
      last_r  <= last_s;
      hcnt_r  <= hcnt_s;
      busy_r  <= |gnt_s;
    end
  end

  assign gnt  = gnt_r;
  assign sel  = sel_r;
  assign busy = busy_r;

endmodule

// File: tb/tb_mux_rr_sched.sv
// Directed self-checking bench for mux_rr_sched with hand-computed grant sequences.
module tb_mux_rr_sched;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       busy;

  int n_tests;
  int n_fail;

  mux_rr_sched #(.MAX_HOLD(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .gnt   (gnt),
    .sel   (sel),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One rising edge, then sample on the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = 8'h00;
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if (gnt !== 8'h00) begin $display("FAIL reset_gnt got %h want 00", gnt); n_fail++; end
    n_tests++;
    if (sel !== 3'd0) begin $display("FAIL reset_sel got %0d want 0", sel); n_fail++; end
    n_tests++;
    if (busy !== 1'b0) begin $display("FAIL reset_busy got %b want 0", busy); n_fail++; end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    req = 8'b0000_0100;
    step();
    n_tests++;
    if (gnt !== 8'b0000_0100) begin $display("FAIL single_gnt got %b want 00000100", gnt); n_fail++; end
    n_tests++;
    if (sel !== 3'd2) begin $display("FAIL single_sel got %0d want 2", sel); n_fail++; end
    n_tests++;
    if (busy !== 1'b1) begin $display("FAIL single_busy got %b want 1", busy); n_fail++; end
    req = 8'h00;
    step();
    n_tests++;
    if (gnt !== 8'h00) begin $display("FAIL drop_gnt got %b want 0", gnt); n_fail++; end
    n_tests++;
    if (busy !== 1'b0) begin $display("FAIL drop_busy got %b want 0", busy); n_fail++; end
    n_tests++;
    if (sel !== 3'd2) begin $display("FAIL drop_sel_hold got %0d want 2", sel); n_fail++; end
  endtask

  task automatic test_rotation();
    logic [2:0] exp_sel;
    logic [7:0] exp_gnt;
    do_reset();
    req = 8'hFF;
    for (int c = 0; c < 36; c++) begin
      step();
      exp_sel = 3'((c / 4) % 8);
      exp_gnt = 8'b0000_0001 << exp_sel;
      n_tests++;
      if (sel !== exp_sel || gnt !== exp_gnt) begin
        $display("FAIL rotation cyc %0d got sel %0d gnt %b want sel %0d gnt %b", c, sel, gnt, exp_sel, exp_gnt);
        n_fail++;
      end
    end
    req = 8'h00;
    step();
  endtask

  task automatic test_back_to_back();
    do_reset();
    req = 8'b0010_0000;
    step();
    n_tests++;
    if (sel !== 3'd5) begin $display("FAIL b2b_first got %0d want 5", sel); n_fail++; end
    req = 8'b0000_1000;
    step();
    n_tests++;
    if (sel !== 3'd3 || gnt !== 8'b0000_1000 || busy !== 1'b1) begin
      $display("FAIL b2b_wrap got sel %0d gnt %b busy %b want 3 00001000 1", sel, gnt, busy);
      n_fail++;
    end
    req = 8'b1000_0010;
    step();
    n_tests++;
    if (sel !== 3'd7) begin $display("FAIL b2b_order got %0d want 7", sel); n_fail++; end
    req = 8'h00;
    step();
    n_tests++;
    if (gnt !== 8'h00 || sel !== 3'd7) begin
      $display("FAIL b2b_idle got gnt %b sel %0d want 0 7", gnt, sel);
      n_fail++;
    end
  endtask

  task automatic test_hold_saturate();
    logic [3:0] exp_h;
    do_reset();
    req = 8'b0100_0000;
    for (int c = 0; c < 20; c++) begin
      step();
      exp_h = (c >= 14) ? 4'd15 : 4'(c + 1);
      n_tests++;
      if (gnt !== 8'b0100_0000 || dut.hcnt_r !== exp_h) begin
        $display("FAIL hold cyc %0d got gnt %b hcnt %0d want 01000000 %0d", c, gnt, dut.hcnt_r, exp_h);
        n_fail++;
      end
    end
    req = 8'b0100_0001;
    step();
    n_tests++;
    if (sel !== 3'd0) begin $display("FAIL hold_competitor got %0d want 0", sel); n_fail++; end
    req = 8'h00;
    step();
  endtask

  task automatic test_edge_pair();
    do_reset();
    req = 8'b1000_0001;
    step();
    n_tests++;
    if (sel !== 3'd0) begin $display("FAIL pair_first got %0d want 0", sel); n_fail++; end
    step();
    step();
    step();
    n_tests++;
    if (sel !== 3'd0) begin $display("FAIL pair_hold got %0d want 0", sel); n_fail++; end
    step();
    n_tests++;
    if (sel !== 3'd7 || gnt !== 8'b1000_0000) begin
      $display("FAIL pair_rotate got sel %0d gnt %b want 7 10000000", sel, gnt);
      n_fail++;
    end
    req = 8'h00;
    step();
  endtask

  task automatic test_async_reset();
    do_reset();
    req = 8'b0001_0000;
    step();
    n_tests++;
    if (sel !== 3'd4) begin $display("FAIL areset_pre got %0d want 4", sel); n_fail++; end
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (gnt !== 8'h00 || busy !== 1'b0 || sel !== 3'd0) begin
      $display("FAIL areset_now got gnt %b busy %b sel %0d want 0 0 0", gnt, busy, sel);
      n_fail++;
    end
    req = 8'hFF;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    n_tests++;
    if (sel !== 3'd0 || gnt !== 8'b0000_0001) begin
      $display("FAIL areset_first got sel %0d gnt %b want 0 00000001", sel, gnt);
      n_fail++;
    end
    req = 8'h00;
    step();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    req     = 8'h00;
    test_reset();
    test_single();
    test_rotation();
    test_back_to_back();
    test_hold_saturate();
    test_edge_pair();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
